// File: rtl/rv_clint.sv
// rv_clint: core-local interruptor with the shared mtime counter, per-hart mtimecmp and msip registers.
// Ports: CLK/RST_X, 32-bit word register port (w_addr/w_wdata/w_we/w_re -> r_rdata/r_rvalid), w_mtime, w_mtip, w_msip.
module rv_clint #(
    parameter int unsigned N_HARTS  = 1,
    parameter int unsigned TICK_DIV = 1
) (
    input  logic               CLK,
    input  logic               RST_X,
    input  logic [15:0]        w_addr,
    input  logic [31:0]        w_wdata,
    input  logic               w_we,
    input  logic               w_re,
    output logic [31:0]        r_rdata,
    output logic               r_rvalid,
    output logic [63:0]        w_mtime,
    output logic [N_HARTS-1:0] w_mtip,
    output logic [N_HARTS-1:0] w_msip
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]      presc_q, presc_d;
    logic [63:0]        mtime_q, mtime_d;
    logic [63:0]        cmp_q [N_HARTS];
    logic [63:0]        cmp_d [N_HARTS];
    logic [N_HARTS-1:0] msip_q, msip_d;
    logic [N_HARTS-1:0] mtip_q, mtip_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q;

    logic               tick;
    logic               sel_msip;
    logic               sel_cmp;
    logic               sel_mtime;
    logic               hi_word;
    logic [11:0]        msip_idx;
    logic [10:0]        cmp_idx;
    logic               unused_addr;

    assign unused_addr = ^w_addr[1:0];

    // Region decode: msip 0x0000-0x3FFF, mtimecmp 0x4000-0x7FFF,
    // mtime is the single doubleword at 0xBFF8.
    assign sel_msip  = (w_addr[15:14] == 2'b00);
    assign sel_cmp   = (w_addr[15:14] == 2'b01);
    assign sel_mtime = (w_addr[15:3] == 13'h17FF);
    assign hi_word   = w_addr[2];
    assign msip_idx  = w_addr[13:2];
    assign cmp_idx   = w_addr[13:3];

    assign tick = (presc_q == PMAX);

    // Prescaler and mtime. A word write overrides the tick for the whole
    // register: the untouched word keeps its current value.
    always_comb begin
        presc_d = tick ? '0 : PW'(presc_q + 1'b1);
        mtime_d = tick ? (mtime_q + 64'd1) : mtime_q;
        if (w_we && sel_mtime) begin
            if (hi_word) begin
                mtime_d = {w_wdata, mtime_q[31:0]};
            end else begin
                mtime_d = {mtime_q[63:32], w_wdata};
            end
        end
    end

    // Per-hart writes; out-of-range hart indices match nothing.
    always_comb begin
        msip_d = msip_q;
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            cmp_d[h] = cmp_q[h];
            if (w_we && sel_msip && (32'(msip_idx) == h)) begin
                msip_d[h] = w_wdata[0];
            end
            if (w_we && sel_cmp && (32'(cmp_idx) == h)) begin
                if (hi_word) begin
                    cmp_d[h][63:32] = w_wdata;
                end else begin
                    cmp_d[h][31:0] = w_wdata;
                end
            end
        end
    end

    // Timer compare on pre-update state, so w_mtip lags by one cycle.
    always_comb begin
        mtip_d = '0;
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            mtip_d[h] = (mtime_q >= cmp_q[h]);
        end
    end

    // Read mux over current state; a same-cycle write is not visible.
    always_comb begin
        rdata_d = '0;
        if (sel_mtime) begin
            rdata_d = hi_word ? mtime_q[63:32] : mtime_q[31:0];
        end
        for (int unsigned h = 0; h < N_HARTS; h++) begin
            if (sel_msip && (32'(msip_idx) == h)) begin
                rdata_d = {31'd0, msip_q[h]};
            end
            if (sel_cmp && (32'(cmp_idx) == h)) begin
                rdata_d = hi_word ? cmp_q[h][63:32] : cmp_q[h][31:0];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            presc_q  <= '0;
            mtime_q  <= '0;
            msip_q   <= '0;
            mtip_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                cmp_q[h] <= '1;
            end
        end else begin
            presc_q  <= presc_d;
            mtime_q  <= mtime_d;
            msip_q   <= msip_d;
            mtip_q   <= mtip_d;
            rvalid_q <= w_re;
            if (w_re) begin
                rdata_q <= rdata_d;
            end
            for (int unsigned h = 0; h < N_HARTS; h++) begin
                cmp_q[h] <= cmp_d[h];
            end
        end
    end

    assign r_rdata  = rdata_q;
    assign r_rvalid = rvalid_q;
    assign w_mtime  = mtime_q;
    assign w_mtip   = mtip_q;
    assign w_msip   = msip_q;

endmodule

// File: tb/tb_rv_clint.sv
// tb_rv_clint: directed checks of rv_clint register port, timer, compare and reset.
// Two instances: N_HARTS=2 with TICK_DIV=1 and TICK_DIV=4.
module tb_rv_clint;

    logic        CLK;
    logic        RST_X;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_we;
    logic        w_re;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic [63:0] w_mtime;
    logic [1:0]  w_mtip;
    logic [1:0]  w_msip;

    logic [31:0] r_rdata4;
    logic        r_rvalid4;
    logic [63:0] w_mtime4;
    logic [1:0]  w_mtip4;
    logic [1:0]  w_msip4;

    int n_pass;
    int n_total;

    rv_clint #(.N_HARTS(2), .TICK_DIV(1)) dut (
        .CLK(CLK), .RST_X(RST_X), .w_addr(w_addr), .w_wdata(w_wdata),
        .w_we(w_we), .w_re(w_re), .r_rdata(r_rdata), .r_rvalid(r_rvalid),
        .w_mtime(w_mtime), .w_mtip(w_mtip), .w_msip(w_msip)
    );

    rv_clint #(.N_HARTS(2), .TICK_DIV(4)) dut4 (
        .CLK(CLK), .RST_X(RST_X), .w_addr(w_addr), .w_wdata(w_wdata),
        .w_we(w_we), .w_re(w_re), .r_rdata(r_rdata4), .r_rvalid(r_rvalid4),
        .w_mtime(w_mtime4), .w_mtip(w_mtip4), .w_msip(w_msip4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic        re;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        ev;
        logic [31:0] erd;
        logic [1:0]  emsip;
    } vec_t;

    vec_t tbl [18];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic re,
                         input logic [15:0] addr, input logic [31:0] wd);
        w_we    = we;
        w_re    = re;
        w_addr  = addr;
        w_wdata = wd;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        RST_X   = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 32'h0);

        tbl[0]  = '{1'b0, 1'b1, 16'h4000, 32'h0, 1'b1, 32'hFFFF_FFFF, 2'b00};
        tbl[1]  = '{1'b0, 1'b1, 16'h4004, 32'h0, 1'b1, 32'hFFFF_FFFF, 2'b00};
        tbl[2]  = '{1'b0, 1'b1, 16'h400C, 32'h0, 1'b1, 32'hFFFF_FFFF, 2'b00};
        tbl[3]  = '{1'b0, 1'b1, 16'hBFFC, 32'h0, 1'b1, 32'h0, 2'b00};
        tbl[4]  = '{1'b1, 1'b0, 16'h0004, 32'hFFFF_FFFF, 1'b0, 32'h0, 2'b10};
        tbl[5]  = '{1'b0, 1'b1, 16'h0004, 32'h0, 1'b1, 32'h1, 2'b10};
        tbl[6]  = '{1'b0, 1'b1, 16'h0000, 32'h0, 1'b1, 32'h0, 2'b10};
        tbl[7]  = '{1'b1, 1'b0, 16'h0008, 32'hFFFF_FFFF, 1'b0, 32'h0, 2'b10};
        tbl[8]  = '{1'b0, 1'b1, 16'h0008, 32'h0, 1'b1, 32'h0, 2'b10};
        tbl[9]  = '{1'b1, 1'b0, 16'h4000, 32'h11, 1'b0, 32'h0, 2'b10};
        tbl[10] = '{1'b1, 1'b1, 16'h4000, 32'h22, 1'b1, 32'h11, 2'b10};
        tbl[11] = '{1'b0, 1'b1, 16'h4000, 32'h0, 1'b1, 32'h22, 2'b10};
        tbl[12] = '{1'b0, 1'b1, 16'h4010, 32'h0, 1'b1, 32'h0, 2'b10};
        tbl[13] = '{1'b0, 1'b1, 16'h2000, 32'h0, 1'b1, 32'h0, 2'b10};
        tbl[14] = '{1'b1, 1'b1, 16'h0000, 32'h1, 1'b1, 32'h0, 2'b11};
        tbl[15] = '{1'b0, 1'b1, 16'h0000, 32'h0, 1'b1, 32'h1, 2'b11};
        tbl[16] = '{1'b1, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h1, 2'b10};
        tbl[17] = '{1'b0, 1'b0, 16'h0000, 32'h0, 1'b0, 32'h1, 2'b10};

        step();
        step();
        chk("rst_mtime", w_mtime, 64'h0);
        chk("rst_mtip", 64'(w_mtip), 64'h0);
        chk("rst_msip", 64'(w_msip), 64'h0);
        chk("rst_rvalid", 64'(r_rvalid), 64'h0);
        chk("rst_rdata", 64'(r_rdata), 64'h0);
        chk("rst_mtime4", w_mtime4, 64'h0);
        RST_X = 1'b1;

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].we, tbl[i].re, tbl[i].addr, tbl[i].wdata);
            step();
            chk($sformatf("v%0d_rvalid", i), 64'(r_rvalid), 64'(tbl[i].ev));
            chk($sformatf("v%0d_rdata", i), 64'(r_rdata), 64'(tbl[i].erd));
            chk($sformatf("v%0d_msip", i), 64'(w_msip), 64'(tbl[i].emsip));
        end
        drive(1'b0, 1'b0, 16'h0, 32'h0);

        // mtimecmp[1] match timing
        drive(1'b1, 1'b0, 16'hBFFC, 32'h0);
        step();
        drive(1'b1, 1'b0, 16'hBFF8, 32'h1000);
        step();
        chk("mt_set", w_mtime, 64'h1000);
        drive(1'b1, 1'b0, 16'h400C, 32'h0);
        step();
        drive(1'b1, 1'b0, 16'h4008, 32'h1007);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("cmp_mt", w_mtime, 64'h1002);
        chk("cmp_mtip0", 64'(w_mtip), 64'h0);
        for (int i = 0; i < 5; i++) begin
            step();
        end
        chk("cmp_mt_eq", w_mtime, 64'h1007);
        chk("cmp_mtip_pre", 64'(w_mtip), 64'h0);
        step();
        chk("cmp_mtip_rise", 64'(w_mtip), 64'h2);
        drive(1'b1, 1'b0, 16'h400C, 32'hFFFF_FFFF);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("cmp_mtip_hold", 64'(w_mtip), 64'h2);
        step();
        chk("cmp_mtip_fall", 64'(w_mtip), 64'h0);

        // carry into the high word, then a high-word write with no tick
        drive(1'b1, 1'b0, 16'hBFFC, 32'h0);
        step();
        drive(1'b1, 1'b0, 16'hBFF8, 32'hFFFF_FFFE);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("carry_set", w_mtime, 64'h0000_0000_FFFF_FFFE);
        step();
        step();
        chk("carry_wrap", w_mtime, 64'h0000_0001_0000_0000);
        step();
        chk("carry_plus1", w_mtime, 64'h0000_0001_0000_0001);
        drive(1'b1, 1'b0, 16'hBFFC, 32'h5);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("hi_wr_notick", w_mtime, 64'h0000_0005_0000_0001);
        drive(1'b0, 1'b1, 16'hBFFC, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("rd_mtime_hi", 64'(r_rdata), 64'h5);

        // reset together with a read
        RST_X = 1'b0;
        drive(1'b0, 1'b1, 16'h4000, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("mr_rvalid", 64'(r_rvalid), 64'h0);
        chk("mr_rdata", 64'(r_rdata), 64'h0);
        chk("mr_mtime", w_mtime, 64'h0);
        chk("mr_msip", 64'(w_msip), 64'h0);
        chk("mr_mtip", 64'(w_mtip), 64'h0);
        RST_X = 1'b1;

        // prescaler spacing on the TICK_DIV=4 instance
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 3) chk("div4_c3", w_mtime4, 64'd0);
            if (i == 4) chk("div4_c4", w_mtime4, 64'd1);
            if (i == 7) chk("div4_c7", w_mtime4, 64'd1);
            if (i == 8) chk("div4_c8", w_mtime4, 64'd2);
            if (i == 40) chk("div4_c40", w_mtime4, 64'd10);
            if (i == 40) chk("div1_c40", w_mtime, 64'd40);
        end

        drive(1'b0, 1'b1, 16'h4000, 32'h0);
        step();
        chk("mr_cmp_lo", 64'(r_rdata), 64'hFFFF_FFFF);
        drive(1'b0, 1'b1, 16'h0004, 32'h0);
        step();
        drive(1'b0, 1'b0, 16'h0, 32'h0);
        chk("mr_msip_rd", 64'(r_rdata), 64'h0);
        chk("mr_rvalid_rd", 64'(r_rvalid), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv_clint.md
Name: rv_clint

Overview:
Core-local interruptor for the multi-hart RV cluster. It owns the 64-bit mtime counter, one 64-bit mtimecmp per hart and one msip bit per hart. It drives the per-hart w_mtip/w_msip vectors and the shared w_mtime bus that feed the cluster directly. Software accesses it through a simple 32-bit word register port from the memory controller.

Parameters:
N_HARTS, 1, number of harts served; width of the interrupt vectors.
TICK_DIV, 1, CLK cycles per mtime increment (>=1); 1 means +1 every cycle.

Ports:
CLK  in  1  clock
RST_X  in  1  synchronous active-low reset
w_addr  in  16  byte offset within CLINT window; bits [1:0] ignored
w_wdata  in  32  write data
w_we  in  1  write strobe, one word per cycle
w_re  in  1  read strobe
r_rdata  out  32  read data, valid with r_rvalid
r_rvalid  out  1  pulses 1 cycle after an accepted w_re
w_mtime  out  64  current mtime value (register output)
w_mtip  out  N_HARTS  machine timer interrupt pending per hart
w_msip  out  N_HARTS  machine software interrupt pending per hart

Behaviour:
- Clock/reset: one clock CLK; reset RST_X is synchronous and active-low; all state is sampled on posedge CLK.
- Reset values: mtime=0; every mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; msip=0; prescaler=0; r_rdata=0; r_rvalid=0; w_mtip=0; w_msip=0.
- Address map (word offsets):
  - msip[h] at 0x0000+4h; only bit 0 is writable, bits [31:1] read 0.
  - mtimecmp[h] low word at 0x4000+8h, high word at 0x4004+8h.
  - mtime low word at 0xBFF8, high word at 0xBFFC.
- Hart index h >= N_HARTS, or any unmapped offset: writes are ignored; reads return 0 with r_rvalid still pulsed.
- Prescaler counts 0..TICK_DIV-1. In the cycle it equals TICK_DIV-1 it wraps to 0 and mtime increments by 1. Full 64-bit carry; 2^64-1 wraps to 0.
- Writes to mtime:
  - A write to a mtime word replaces that word only. The other word keeps its current value, with no increment applied in that cycle even if a tick occurs.
  - The prescaler is not disturbed by mtime writes.
- Read latency: exactly 1 cycle. r_rdata holds the value present before any same-cycle write, so a same-address read+write returns the old value. r_rdata holds its last value while r_rvalid=0.
- w_re and w_we asserted in the same cycle: both are performed, possibly to different addresses.
- w_mtip[h] is a register updated every cycle with (mtime >= mtimecmp[h]), unsigned 64-bit compare, using pre-update values. Latency is therefore 1 cycle from the state change to the output. It is level, not sticky: raising mtimecmp above mtime clears it on the following cycle.
- w_msip[h] is driven directly from the msip register: it follows the write on the next cycle.
- w_mtime is the mtime register itself; all harts see the same value in the same cycle.
- Reset asserted mid-operation: all state returns to reset values on that edge. A pending read is dropped and r_rvalid=0 on the next cycle.

Test Plan:
1. Reset, N_HARTS=2, TICK_DIV=1 -> w_mtime=0, w_mtip=2'b00, w_msip=2'b00, r_rvalid=0; reads of 0x4000/0x4004 return 0xFFFFFFFF.
2. TICK_DIV=4, run 40 cycles after reset release -> w_mtime=10; increments are spaced exactly 4 cycles apart.
3. Write mtime lo=0xFFFFFFFE, hi=0 with TICK_DIV=1 -> three cycles later w_mtime=0x1_00000001; the carry into the high word is correct.
4. Write mtimecmp[1]=mtime+5 (hi then lo) -> w_mtip[1] rises exactly 1 cycle after mtime reaches the compare value and w_mtip[0] stays 0. Then write mtimecmp[1] hi=0xFFFFFFFF -> w_mtip[1] falls on the next cycle.
5. Write 0xFFFFFFFF to 0x0004, N_HARTS=2 -> w_msip=2'b10 and readback=0x00000001. Write to 0x0008 -> ignored; read of 0x0008 returns 0 with r_rvalid=1.
6. Same-cycle w_re+w_we to 0x4000 with old=0x11, new=0x22 -> r_rdata=0x11; a following read returns 0x22. Assert RST_X=0 on the cycle after a w_re -> r_rvalid=0 and all registers are back at reset values.
